// File: rtl/serial_pkg.sv
// Shared types for the bit-serial adder datapath (adder, serializer, word assembler).
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

    localparam int unsigned DROP_CW_DEF = 8;

endpackage

// File: rtl/serial_out_reg.sv
// One-word holding register with a valid/ready output port.
// 'free' means a word offered this cycle can be captured; 'load' means it is.
module serial_out_reg
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free,
    output logic             load
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Slot frees up when empty or when the held word leaves this same edge.
    always_comb begin
        free    = !valid_q || ready;
        load    = load_req && free;
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Collects an LSB-first serial result stream into WIDTH-bit words and hands them to a
// valid/ready consumer. The upstream cannot stall: words with nowhere to go are dropped.
module serial_word_assembler
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DROP_CW = DROP_CW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_valid,
    input  logic               bit_data,
    input  logic               bit_first,
    output logic [WIDTH-1:0]   word_data,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               err_frame,
    output logic               err_ovf,
    output logic [DROP_CW-1:0] drop_cnt
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    asm_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   merged;
    logic               done;
    logic               frame_d;
    logic               ovf_d;
    logic               err_frame_q, err_ovf_q;
    logic [DROP_CW-1:0] drop_q, drop_d;
    logic               slot_free, slot_load;

    // Framing FSM and shift register; 'merged' is the shift reg with this bit inserted.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        shift_d         = shift_q;
        frame_d         = 1'b0;
        done            = 1'b0;
        merged          = shift_q;
        merged[cnt_q]   = bit_data;
        if (bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bit_first) begin
                        shift_d    = '0;
                        shift_d[0] = bit_data;
                        cnt_d      = CW'(1);
                        state_d    = COLLECT;
                    end else begin
                        frame_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (bit_first) begin
                        // Restart: the partial word is thrown away, this bit is bit 0.
                        frame_d    = 1'b1;
                        shift_d    = '0;
                        shift_d[0] = bit_data;
                        cnt_d      = CW'(1);
                    end else if (cnt_q == CntLast) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shift_d = merged;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    // Overflow detection and saturating drop counter.
    always_comb begin
        ovf_d  = done && !slot_free;
        drop_d = drop_q;
        if (done && !slot_load && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CW'(1);
        end
    end

    // Assembler state and registered error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            err_frame_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            err_frame_q <= frame_d;
            err_ovf_q   <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    serial_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load_req  (done),
        .load_data (merged),
        .ready     (word_ready),
        .data      (word_data),
        .valid     (word_valid),
        .free      (slot_free),
        .load      (slot_load)
    );

    assign err_frame = err_frame_q;
    assign err_ovf   = err_ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler (WIDTH=4): directed vector table, hand-written
// reset/saturation sequences, and randomized traffic against a queue-based model.
module tb_serial_word_assembler;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_valid, bit_data, bit_first, word_ready;
    logic [3:0] word_data;
    logic       word_valid, err_frame, err_ovf;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_word_assembler #(
        .WIDTH   (4),
        .DROP_CW (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .bit_first  (bit_first),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .err_frame  (err_frame),
        .err_ovf    (err_ovf),
        .drop_cnt   (drop_cnt)
    );

    typedef struct {
        logic       bv, bd, bf, rdy;
        logic [3:0] wd;
        logic       wv, ef, ov;
        logic [7:0] dc;
    } vec_t;

    vec_t vq[$];

    // Reference model: bits gathered in a queue, one-slot holding register.
    bit         m_q[$];
    logic [3:0] m_word;
    logic       m_valid, m_ef, m_ov;
    int         m_drop;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic bv, bd, bf, rdy, input logic [3:0] wd,
                       input logic wv, ef, ov, input logic [7:0] dc);
        vec_t v;
        v.bv = bv; v.bd = bd; v.bf = bf; v.rdy = rdy;
        v.wd = wd; v.wv = wv; v.ef = ef; v.ov = ov; v.dc = dc;
        vq.push_back(v);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_word  = '0;
        m_valid = 1'b0;
        m_ef    = 1'b0;
        m_ov    = 1'b0;
        m_drop  = 0;
    endtask

    task automatic model_step(input logic bv, bd, bf, rdy);
        logic       done;
        logic [3:0] w;
        done = 1'b0;
        w    = '0;
        m_ef = 1'b0;
        m_ov = 1'b0;
        if (bv) begin
            if (bf) begin
                if (m_q.size() != 0) m_ef = 1'b1;
                m_q.delete();
                m_q.push_back(bd);
            end else if (m_q.size() == 0) begin
                m_ef = 1'b1;
            end else begin
                m_q.push_back(bd);
                if (m_q.size() == 4) begin
                    done = 1'b1;
                    for (int k = 0; k < 4; k++) w[k] = m_q[k];
                    m_q.delete();
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_word  = w;
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic bv, bd, bf, rdy);
        bit_valid  = bv;
        bit_data   = bd;
        bit_first  = bf;
        word_ready = rdy;
        model_step(bv, bd, bf, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, " word_data"}, int'(word_data), int'(m_word));
        check({tag, " word_valid"}, int'(word_valid), int'(m_valid));
        check({tag, " err_frame"}, int'(err_frame), int'(m_ef));
        check({tag, " err_ovf"}, int'(err_ovf), int'(m_ov));
        check({tag, " drop_cnt"}, int'(drop_cnt), m_drop);
    endtask

    task automatic do_reset();
        bit_valid = 0; bit_data = 0; bit_first = 0; word_ready = 0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_word(input logic [3:0] w, input logic rdy);
        for (int k = 0; k < 4; k++) step(1'b1, w[k], k == 0, rdy);
    endtask

    initial begin
        // Directed table: cases 1-4 run back to back from reset.
        // 1: bits 1,0,1,1, consumer ready.
        add(1,1,1,1, 4'h0,0,0,0, 0);
        add(1,0,0,1, 4'h0,0,0,0, 0);
        add(1,1,0,1, 4'h0,0,0,0, 0);
        add(1,1,0,1, 4'hd,1,0,0, 0);
        add(0,0,0,1, 4'hd,0,0,0, 0);
        // 2: 0110 then 0011, consumer stalled: second word dropped.
        add(1,0,1,0, 4'hd,0,0,0, 0);
        add(1,1,0,0, 4'hd,0,0,0, 0);
        add(1,1,0,0, 4'hd,0,0,0, 0);
        add(1,0,0,0, 4'h6,1,0,0, 0);
        add(1,1,1,0, 4'h6,1,0,0, 0);
        add(1,1,0,0, 4'h6,1,0,0, 0);
        add(1,0,0,0, 4'h6,1,0,0, 0);
        add(1,0,0,0, 4'h6,1,0,1, 1);
        add(0,0,0,0, 4'h6,1,0,0, 1);
        add(0,0,0,1, 4'h6,0,0,0, 1);
        // 3: same, but ready during the second completion: back-to-back swap.
        add(1,0,1,0, 4'h6,0,0,0, 1);
        add(1,1,0,0, 4'h6,0,0,0, 1);
        add(1,1,0,0, 4'h6,0,0,0, 1);
        add(1,0,0,0, 4'h6,1,0,0, 1);
        add(1,1,1,0, 4'h6,1,0,0, 1);
        add(1,1,0,0, 4'h6,1,0,0, 1);
        add(1,0,0,0, 4'h6,1,0,0, 1);
        add(1,0,0,1, 4'h3,1,0,0, 1);
        add(0,0,0,1, 4'h3,0,0,0, 1);
        // 4: bits 1,1 then a restart with 0,0,1,0.
        add(1,1,1,0, 4'h3,0,0,0, 1);
        add(1,1,0,0, 4'h3,0,0,0, 1);
        add(1,0,1,0, 4'h3,0,1,0, 1);
        add(1,0,0,0, 4'h3,0,0,0, 1);
        add(1,1,0,0, 4'h3,0,0,0, 1);
        add(1,0,0,0, 4'h4,1,0,0, 1);
        add(0,0,0,1, 4'h4,0,0,0, 1);

        do_reset();
        check("reset word_data", int'(word_data), 0);
        check("reset word_valid", int'(word_valid), 0);
        check("reset err_frame", int'(err_frame), 0);
        check("reset err_ovf", int'(err_ovf), 0);
        check("reset drop_cnt", int'(drop_cnt), 0);

        foreach (vq[i]) begin
            step(vq[i].bv, vq[i].bd, vq[i].bf, vq[i].rdy);
            check($sformatf("row%0d word_data", i), int'(word_data), int'(vq[i].wd));
            check($sformatf("row%0d word_valid", i), int'(word_valid), int'(vq[i].wv));
            check($sformatf("row%0d err_frame", i), int'(err_frame), int'(vq[i].ef));
            check($sformatf("row%0d err_ovf", i), int'(err_ovf), int'(vq[i].ov));
            check($sformatf("row%0d drop_cnt", i), int'(drop_cnt), int'(vq[i].dc));
        end

        // 5: stray bit in IDLE, then reset two bits into a word.
        do_reset();
        step(1, 1, 0, 1);
        check("stray err_frame", int'(err_frame), 1);
        check("stray word_valid", int'(word_valid), 0);
        step(0, 0, 0, 1);
        check("stray err_frame clears", int'(err_frame), 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        reset = 1'b1;
        #1;
        check("midword reset word_valid", int'(word_valid), 0);
        check("midword reset word_data", int'(word_data), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        send_word(4'b1001, 1'b0);
        check("post-reset word_data", int'(word_data), 4'h9);
        check("post-reset word_valid", int'(word_valid), 1);
        check("post-reset err_frame", int'(err_frame), 0);
        check_model("post-reset model");

        // 6: drop counter saturation with the consumer stalled.
        do_reset();
        for (int n = 0; n < 301; n++) send_word(4'(n), 1'b0);
        check("sat drop_cnt", int'(drop_cnt), 8'hff);
        check("sat word_data", int'(word_data), 0);
        check_model("sat model");

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic bv, bd, bf, rdy;
            bv  = ($urandom_range(0, 3) != 0);
            bd  = 1'($urandom);
            bf  = (m_q.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            step(bv, bd, bf, rdy);
            check_model($sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
